// File: rtl/lane_sensor_encoder_if.sv
// lane_sensor_encoder_if
//   Bundles the detector inputs and the demand/queue outputs of the lane
//   sensor encoder. The clock and reset stay outside this bundle.
//   arr_raw[3:0]  raw arrival detectors, bit0=A .. bit3=D (asynchronous)
//   dep_raw[3:0]  raw departure detectors, same bit order
//   Sa..Sd        2-bit registered demand levels per lane
//   queue_len     registered queue counts, lane A in [QW-1:0], then B, C, D
//   master: the side that drives the detectors (testbench / pad ring)
//   slave : the encoder itself
interface lane_sensor_encoder_if #(
  parameter int QW = 5
);
  logic [3:0]      arr_raw;
  logic [3:0]      dep_raw;
  logic [1:0]      Sa;
  logic [1:0]      Sb;
  logic [1:0]      Sc;
  logic [1:0]      Sd;
  logic [4*QW-1:0] queue_len;

  modport master (
    output arr_raw, dep_raw,
    input  Sa, Sb, Sc, Sd, queue_len
  );

  modport slave (
    input  arr_raw, dep_raw,
    output Sa, Sb, Sc, Sd, queue_len
  );
endinterface

// File: rtl/lane_sensor_encoder.sv
// lane_sensor_encoder
//   Per-lane demand front end for the four-way light controller. Each raw
//   arrival/departure detector is synchronized (2 FF), debounced and turned
//   into a one-cycle rising-edge event. Events drive a saturating per-lane
//   queue count, which is quantized into a registered 2-bit demand level.
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset, clears every flop
//   bus    lane_sensor_encoder_if.slave (arr_raw/dep_raw in, Sa..Sd and
//          queue_len out)

// ---------------------------------------------------------------------------
// lse_deb: synchronizer + debounce + rising-edge detect for one detector.
//   raw  asynchronous detector input
//   evt  one-cycle pulse on each accepted low->high transition
// ---------------------------------------------------------------------------
module lse_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic evt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          deb_d, deb_q;
  logic          prev_q;
  logic [CW-1:0] cnt_d, cnt_q;

  // A difference must be seen on DEB_CYCLES consecutive edges; the edge that
  // completes the run updates deb directly, so the counter only needs to
  // reach DEB_CYCLES-1. Any agreeing edge restarts the run.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      cnt_q   <= cnt_d;
    end
  end

  // Held-high detectors produce a single event; falling edges produce none.
  assign evt = deb_q & ~prev_q;
endmodule

// ---------------------------------------------------------------------------
// lse_lane: one lane's arrival/departure conditioning, queue and level.
//   arr_raw/dep_raw  raw detectors for this lane
//   qlen             registered saturating queue count
//   lvl              registered demand level derived from qlen
// ---------------------------------------------------------------------------
module lse_lane #(
  parameter int QW         = 5,
  parameter int DEB_CYCLES = 4,
  parameter int TH1        = 4,
  parameter int TH2        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arr_raw,
  input  logic          dep_raw,
  output logic [QW-1:0] qlen,
  output logic [1:0]    lvl
);
  localparam logic [QW-1:0] QMAX = '1;

  logic          arr_evt, dep_evt;
  logic [QW-1:0] q_d, q_q;
  logic [1:0]    lvl_d, lvl_q;

  lse_deb #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (arr_raw),
    .evt   (arr_evt)
  );

  lse_deb #(.DEB_CYCLES(DEB_CYCLES)) u_dep (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (dep_raw),
    .evt   (dep_evt)
  );

  // Simultaneous arrival and departure cancel; both ends saturate.
  always_comb begin
    q_d = q_q;
    if (arr_evt && !dep_evt && (q_q != QMAX))
      q_d = q_q + 1'b1;
    else if (dep_evt && !arr_evt && (q_q != '0))
      q_d = q_q - 1'b1;
  end

  // Level follows the registered count, so it lags the count by one edge.
  always_comb begin
    if (q_q == '0)
      lvl_d = 2'd0;
    else if (q_q < QW'(TH1))
      lvl_d = 2'd1;
    else if (q_q < QW'(TH2))
      lvl_d = 2'd2;
    else
      lvl_d = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      lvl_q <= 2'd0;
    end else begin
      q_q   <= q_d;
      lvl_q <= lvl_d;
    end
  end

  assign qlen = q_q;
  assign lvl  = lvl_q;
endmodule

// ---------------------------------------------------------------------------
// lane_sensor_encoder: four independent lanes, A..D on bits 0..3.
// ---------------------------------------------------------------------------
module lane_sensor_encoder #(
  parameter int QW         = 5,
  parameter int DEB_CYCLES = 4,
  parameter int TH1        = 4,
  parameter int TH2        = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lane_sensor_encoder_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][QW-1:0] qlen;
  logic [NUM_LANES-1:0][1:0]    lvl;

  // Instance array: bit/element i of each connection goes to lane i.
  lse_lane #(
    .QW         (QW),
    .DEB_CYCLES (DEB_CYCLES),
    .TH1        (TH1),
    .TH2        (TH2)
  ) u_lane [NUM_LANES-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .arr_raw (bus.arr_raw),
    .dep_raw (bus.dep_raw),
    .qlen    (qlen),
    .lvl     (lvl)
  );

  assign bus.Sa        = lvl[0];
  assign bus.Sb        = lvl[1];
  assign bus.Sc        = lvl[2];
  assign bus.Sd        = lvl[3];
  assign bus.queue_len = qlen;
endmodule

// File: tb/tb_lane_sensor_encoder.sv
module tb_lane_sensor_encoder;
  localparam int QW = 5;

  typedef struct {
    int lane;
    bit is_dep;
    int hi;
    int lo;
    int exp_q;
    int exp_lvl;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q [4];
  int   exp_l [4];
  vec_t tbl [$];

  lane_sensor_encoder_if #(.QW(QW)) bus ();

  lane_sensor_encoder #(
    .QW(QW), .DEB_CYCLES(4), .TH1(4), .TH2(10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_q(int lane);
    logic [4*QW-1:0] v;
    v = bus.queue_len;
    return int'(v[lane*QW +: QW]);
  endfunction

  function automatic int get_l(int lane);
    case (lane)
      0: return int'(bus.Sa);
      1: return int'(bus.Sb);
      2: return int'(bus.Sc);
      default: return int'(bus.Sd);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s q[%0d]", tag, i), get_q(i), exp_q[i]);
      chk($sformatf("%s S[%0d]", tag, i), get_l(i), exp_l[i]);
    end
  endtask

  task automatic pulse(int lane, bit is_dep, int hi, int lo);
    if (is_dep) bus.dep_raw[lane] = 1'b1;
    else        bus.arr_raw[lane] = 1'b1;
    repeat (hi) tick();
    bus.dep_raw[lane] = 1'b0;
    bus.arr_raw[lane] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic add(int lane, bit is_dep, int hi, int lo, int q, int l);
    vec_t v;
    v.lane = lane; v.is_dep = is_dep; v.hi = hi; v.lo = lo;
    v.exp_q = q; v.exp_lvl = l;
    tbl.push_back(v);
  endtask

  initial begin
    // ---- vector table (hand-computed expected count/level of that lane) ----
    add(0, 0, 30, 10, 2, 1);   // held high counts once
    add(1, 0, 3, 10, 0, 0);    // 3-cycle glitch rejected
    add(1, 0, 4, 10, 1, 1);    // 4 cycles accepted
    // 12 arrivals on C
    add(2,0,8,8, 1,1); add(2,0,8,8, 2,1); add(2,0,8,8, 3,1); add(2,0,8,8, 4,2);
    add(2,0,8,8, 5,2); add(2,0,8,8, 6,2); add(2,0,8,8, 7,2); add(2,0,8,8, 8,2);
    add(2,0,8,8, 9,2); add(2,0,8,8,10,3); add(2,0,8,8,11,3); add(2,0,8,8,12,3);
    // 12 departures on C, then one extra on an empty queue
    add(2,1,8,8,11,3); add(2,1,8,8,10,3); add(2,1,8,8, 9,2); add(2,1,8,8, 8,2);
    add(2,1,8,8, 7,2); add(2,1,8,8, 6,2); add(2,1,8,8, 5,2); add(2,1,8,8, 4,2);
    add(2,1,8,8, 3,1); add(2,1,8,8, 2,1); add(2,1,8,8, 1,1); add(2,1,8,8, 0,0);
    add(2,1,8,8, 0,0);

    for (int i = 0; i < 4; i++) begin exp_q[i] = 0; exp_l[i] = 0; end
    bus.arr_raw = '0;
    bus.dep_raw = '0;

    // ---- 1. reset then idle ----
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c % 10 == 9) chk_all("idle");
    end

    // ---- 2. single arrival on A, exact latency ----
    bus.arr_raw[0] = 1'b1;               // next edge is edge 0
    for (int k = 0; k <= 7; k++) begin
      tick();                            // now just after edge k
      if (k == 5) chk("lat q@5", get_q(0), 0);
      if (k == 6) begin
        chk("lat q@6", get_q(0), 1);
        chk("lat S@6", get_l(0), 0);
      end
      if (k == 7) chk("lat S@7", get_l(0), 1);
    end
    repeat (2) tick();
    bus.arr_raw[0] = 1'b0;
    repeat (10) tick();
    exp_q[0] = 1; exp_l[0] = 1;
    chk_all("single A");

    // ---- 3/4. table-driven glitch and threshold vectors ----
    foreach (tbl[i]) begin
      pulse(tbl[i].lane, tbl[i].is_dep, tbl[i].hi, tbl[i].lo);
      exp_q[tbl[i].lane] = tbl[i].exp_q;
      exp_l[tbl[i].lane] = tbl[i].exp_lvl;
      chk_all($sformatf("vec%0d", i));
    end

    // ---- 5. saturation on D ----
    for (int n = 0; n < 35; n++) pulse(3, 0, 6, 6);
    repeat (4) tick();
    exp_q[3] = 31; exp_l[3] = 3;
    chk_all("sat D");

    // simultaneous arrival+departure: saturated D and mid-range A unchanged
    bus.arr_raw[3] = 1'b1; bus.dep_raw[3] = 1'b1;
    bus.arr_raw[0] = 1'b1; bus.dep_raw[0] = 1'b1;
    repeat (8) tick();
    bus.arr_raw = '0; bus.dep_raw = '0;
    repeat (10) tick();
    chk_all("simul");

    // ---- 6. reset mid-operation ----
    for (int n = 0; n < 5; n++) pulse(0, 0, 6, 6);
    repeat (4) tick();
    exp_q[0] = 7; exp_l[0] = 2;
    chk_all("A=7");
    bus.arr_raw[0] = 1'b1;
    repeat (2) tick();                   // arrival sits in the synchronizer
    #3 rst_n = 1'b0;                     // between edges
    #1;
    for (int i = 0; i < 4; i++) begin exp_q[i] = 0; exp_l[i] = 0; end
    chk_all("async rst");
    bus.arr_raw[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk_all("post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
